// File: rtl/traffic_log_pkg.sv
// Shared types and constants for the traffic log reader.
// The state encoding includes SUM. SUM is only reachable when the design is
// built with TRAFFIC_LOG_CHECKSUM_EN defined.
package traffic_log_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    SUM   = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Level driven on read_Write during a request; this block only reads.
  localparam logic READ_CMD    = 1'b1;
  // Street index of the final street visited by the walk.
  localparam logic LAST_STREET = 1'b1;

endpackage

// File: rtl/log_entry_sequencer.sv
// Street/address walk counter for the traffic log reader.
// Addresses run 0..DEPTH-1 on street 0, then 0..DEPTH-1 on street 1.
// The is_last output flags the final entry of the walk.
module log_entry_sequencer
  import traffic_log_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 128
) (
  input  logic                  clock,
  input  logic                  reset_N,
  input  logic                  clear,
  input  logic                  advance,
  output logic                  street,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  is_last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic                  street_q, street_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic                  addr_last;

  assign addr_last = (address_q == LAST_ADDR);
  assign is_last   = addr_last && (street_q == LAST_STREET);
  assign street    = street_q;
  assign address   = address_q;

  // Next counter value: clear wins, advance steps and wraps into street 1.
  always_comb begin
    street_d  = street_q;
    address_d = address_q;
    if (clear) begin
      street_d  = 1'b0;
      address_d = '0;
    end else if (advance && !is_last) begin
      if (addr_last) begin
        address_d = '0;
        street_d  = LAST_STREET;
      end else begin
        address_d = address_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      street_q  <= 1'b0;
      address_q <= '0;
    end else begin
      street_q  <= street_d;
      address_q <= address_d;
    end
  end

endmodule

// File: rtl/traffic_log_reader.sv
// Traffic log reader: walks every (street, address) entry of the
// Turn_Controller traffic memory. It issues one read per entry and streams
// each captured count to a host over a valid/ready interface.
// Optional feature macro: TRAFFIC_LOG_CHECKSUM_EN. When it is defined, one
// trailing entry carrying the sum of all captured counts is emitted before DONE.
module traffic_log_reader
  import traffic_log_pkg::*;
#(
  parameter int ADDR_WIDTH   = 7,
  parameter int DATA_WIDTH   = 4,
  parameter int DEPTH        = 128,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset_N,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  read_Write,
  output logic                  memory_Enable,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  street,
  input  logic [DATA_WIDTH-1:0] traffic_Street,
  output logic                  log_Valid,
  input  logic                  log_Ready,
  output logic                  log_Street,
  output logic [ADDR_WIDTH-1:0] log_Address,
  output logic [DATA_WIDTH-1:0] log_Data
);

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

  state_e                state_q, state_d;
  logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
  logic [DATA_WIDTH-1:0] log_data_q, log_data_d;

  logic                  seq_street;
  logic [ADDR_WIDTH-1:0] seq_address;
  logic                  seq_is_last;
  logic                  seq_clear;
  logic                  seq_advance;
  logic                  lat_last;
  logic                  capture;

  assign lat_last    = (lat_cnt_q == LAT_LAST);
  assign capture     = (state_q == WAIT) && lat_last;
  assign seq_clear   = (state_q == IDLE) && start && !abort;
  assign seq_advance = (state_q == HOLD) && log_Ready && !abort;

  log_entry_sequencer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_seq (
    .clock   (clock),
    .reset_N (reset_N),
    .clear   (seq_clear),
    .advance (seq_advance),
    .street  (seq_street),
    .address (seq_address),
    .is_last (seq_is_last)
  );

`ifdef TRAFFIC_LOG_CHECKSUM_EN
  localparam int ACC_W = DATA_WIDTH + ADDR_WIDTH + 1;
  logic [ACC_W-1:0] acc_q, acc_d;

  // Running sum of captured counts, cleared when a dump starts.
  always_comb begin
    acc_d = acc_q;
    if (seq_clear) begin
      acc_d = '0;
    end else if (capture) begin
      acc_d = acc_q + ACC_W'(traffic_Street);
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every transition except leaving DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = abort ? DONE : WAIT;
      end
      WAIT: begin
        if (abort)         state_d = DONE;
        else if (lat_last) state_d = HOLD;
      end
      HOLD: begin
        if (abort) begin
          state_d = DONE;
        end else if (log_Ready) begin
          if (!seq_is_last) begin
            state_d = ISSUE;
          end else begin
`ifdef TRAFFIC_LOG_CHECKSUM_EN
            state_d = SUM;
`else
            state_d = DONE;
`endif
          end
        end
      end
      SUM: begin
        if (abort || log_Ready) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latency counter and capture register next values.
  always_comb begin
    lat_cnt_d  = '0;
    log_data_d = log_data_q;
    if (state_q == WAIT && !lat_last) begin
      lat_cnt_d = lat_cnt_q + LAT_W'(1);
    end
    if (capture) begin
      log_data_d = traffic_Street;
    end
  end

  // Latency counter and captured-data registers.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      lat_cnt_q  <= '0;
      log_data_q <= '0;
    end else begin
      lat_cnt_q  <= lat_cnt_d;
      log_data_q <= log_data_d;
    end
  end

  // Output decode from the current state.
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    read_Write    = 1'b0;
    memory_Enable = 1'b0;
    log_Valid     = 1'b0;
    address       = seq_address;
    street        = seq_street;
    log_Street    = seq_street;
    log_Address   = seq_address;
    log_Data      = log_data_q;
    unique case (state_q)
      ISSUE: begin
        busy          = 1'b1;
        memory_Enable = 1'b1;
        read_Write    = READ_CMD;
      end
      WAIT: begin
        busy = 1'b1;
      end
      HOLD: begin
        busy      = 1'b1;
        log_Valid = 1'b1;
      end
      SUM: begin
        busy        = 1'b1;
        log_Valid   = 1'b1;
        log_Street  = LAST_STREET;
        log_Address = '1;
`ifdef TRAFFIC_LOG_CHECKSUM_EN
        log_Data    = acc_q[DATA_WIDTH-1:0];
`endif
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_log_reader.sv
// Bench for traffic_log_reader. Instance A uses DEPTH=4 and READ_LATENCY=1.
// Instance B uses DEPTH=4 and READ_LATENCY=3.
// Each instance has a memory model that returns {street, addr[2:0]} exactly
// READ_LATENCY cycles after an enable pulse, and random garbage otherwise.
module tb_traffic_log_reader;

  localparam int AW  = 7;
  localparam int DW  = 4;
  localparam int DEP = 4;
`ifdef TRAFFIC_LOG_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int NENT = 2 * DEP + CK;

  typedef struct packed {
    logic          st;
    logic [AW-1:0] ad;
    logic [DW-1:0] d;
  } ent_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_N;

  logic start_a, abort_a, ready_a;
  logic busy_a, done_a, rw_a, en_a, st_a, vld_a, lst_a;
  logic [AW-1:0] ad_a, lad_a;
  logic [DW-1:0] traf_a, ld_a;

  logic start_b, abort_b, ready_b;
  logic busy_b, done_b, rw_b, en_b, st_b, vld_b, lst_b;
  logic [AW-1:0] ad_b, lad_b;
  logic [DW-1:0] traf_b, ld_b;

  traffic_log_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .READ_LATENCY(1)) dut_a (
    .clock(clock), .reset_N(reset_N), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .read_Write(rw_a), .memory_Enable(en_a),
    .address(ad_a), .street(st_a), .traffic_Street(traf_a),
    .log_Valid(vld_a), .log_Ready(ready_a), .log_Street(lst_a),
    .log_Address(lad_a), .log_Data(ld_a));

  traffic_log_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .READ_LATENCY(3)) dut_b (
    .clock(clock), .reset_N(reset_N), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .read_Write(rw_b), .memory_Enable(en_b),
    .address(ad_b), .street(st_b), .traffic_Street(traf_b),
    .log_Valid(vld_b), .log_Ready(ready_b), .log_Street(lst_b),
    .log_Address(lad_b), .log_Data(ld_b));

  // Memory models
  logic [DW-1:0] garb;
  logic          a_v;
  logic [DW-1:0] a_d;
  logic [2:0]    b_v;
  logic [DW-1:0] b_d [3];

  always @(posedge clock) begin
    garb   <= DW'($urandom);
    a_v    <= en_a;
    a_d    <= {st_a, ad_a[2:0]};
    b_v    <= {b_v[1:0], en_b};
    b_d[0] <= {st_b, ad_b[2:0]};
    b_d[1] <= b_d[0];
    b_d[2] <= b_d[1];
  end
  assign traf_a = a_v    ? a_d    : garb;
  assign traf_b = b_v[2] ? b_d[2] : garb;

  // Hand-computed expected entries: s0a0..s0a3, s1a0..s1a3, then the checksum 44 mod 16.
  logic [DW-1:0] data_tab [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11, 4'hC};

  function automatic ent_t exp_entry(input int i);
    ent_t e;
    if (i < 2 * DEP) begin
      e.st = (i >= DEP);
      e.ad = AW'(i % DEP);
    end else begin
      e.st = 1'b1;
      e.ad = 7'h7F;
    end
    e.d = data_tab[i];
    return e;
  endfunction

  int errors = 0;
  int checks = 0;
  ent_t exp_a[$];
  ent_t exp_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitors: pop and compare on every accepted entry.
  always @(negedge clock) begin
    if (reset_N && vld_a && ready_a) begin
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_entry: actual=%0h required=none", {lst_a, lad_a, ld_a});
      end else begin
        ent_t e;
        e = exp_a.pop_front();
        chk("a_entry", {lst_a, lad_a, ld_a}, e);
      end
    end
    if (reset_N && vld_b && ready_b) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_entry: actual=%0h required=none", {lst_b, lad_b, ld_b});
      end else begin
        ent_t e;
        e = exp_b.pop_front();
        chk("b_entry", {lst_b, lad_b, ld_b}, e);
      end
    end
  end

  // read_Write and memory_Enable are only ever high together.
  always @(negedge clock) begin
    if (en_a || rw_a) chk("a_rw_with_enable", rw_a, en_a);
    if (en_b || rw_b) chk("b_rw_with_enable", rw_b, en_b);
  end

  // Instance B: log_Valid must rise exactly READ_LATENCY+1 cycles after each enable.
  int  cyc_b = 0;
  int  last_en_b = 0;
  logic prev_vld_b = 1'b0;
  always @(negedge clock) begin
    cyc_b++;
    if (en_b) last_en_b = cyc_b;
    if (reset_N && vld_b && !prev_vld_b) chk("b_capture_latency", cyc_b - last_en_b, 4);
    prev_vld_b = vld_b;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input bit b);
    tick();
    if (b) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Counts cycles after the start pulse until done is seen.
  task automatic wait_done(input bit b, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == 1) chk("busy_after_start", b ? busy_b : busy_a, 1);
    end while (!(b ? done_b : done_a) && n < 300);
    if (!(b ? done_b : done_a)) begin
      checks++; errors++;
      $display("FAIL done_timeout: actual=no done required=done within 300 cycles");
    end
  endtask

  task automatic wait_valid_a();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!vld_a && n < 50);
    if (!vld_a) begin
      checks++; errors++;
      $display("FAIL valid_timeout: actual=no log_Valid required=log_Valid within 50 cycles");
    end
  endtask

  task automatic accept_one_a();
    wait_valid_a();
    tick();
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
  endtask

  task automatic chk_all_zero_a(input string tag);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_rw"}, rw_a, 0);
    chk({tag, "_en"}, en_a, 0);
    chk({tag, "_addr_street"}, {st_a, ad_a}, 0);
    chk({tag, "_valid"}, vld_a, 0);
    chk({tag, "_log_fields"}, {lst_a, lad_a, ld_a}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    ent_t snap;
    logic seen;
    reset_N = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b0;
    repeat (3) tick();
    chk_all_zero_a("reset");
    reset_N = 1'b1;
    repeat (2) tick();

    // Full dump with log_Ready held high
    ready_a = 1'b1;
    for (int i = 0; i < NENT; i++) exp_a.push_back(exp_entry(i));
    pulse_start(1'b0);
    wait_done(1'b0, n);
    chk("full_dump_cycles", n, 2 * DEP * 3 + 1 + CK);
    chk("busy_low_at_done", busy_a, 0);
    @(negedge clock);
    chk("done_single_pulse", done_a, 0);
    chk("full_dump_all_popped", exp_a.size(), 0);

    // Backpressure in HOLD
    ready_a = 1'b0;
    for (int i = 0; i < NENT; i++) exp_a.push_back(exp_entry(i));
    pulse_start(1'b0);
    wait_valid_a();
    snap = {lst_a, lad_a, ld_a};
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_fields_stable", {lst_a, lad_a, ld_a}, snap);
      chk("bp_valid_held", vld_a, 1);
      seen = seen | en_a;
    end
    chk("bp_no_enable", seen, 0);
    tick();
    ready_a = 1'b1;
    wait_done(1'b0, n);
    chk("bp_all_popped", exp_a.size(), 0);
    tick();

    // abort in HOLD of entry 2
    ready_a = 1'b0;
    exp_a.push_back(exp_entry(0));
    exp_a.push_back(exp_entry(1));
    pulse_start(1'b0);
    accept_one_a();
    accept_one_a();
    wait_valid_a();
    chk("abort_hold_addr", {lst_a, lad_a}, 2);
    tick();
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("abort_valid_dropped", vld_a, 0);
    chk("abort_done", done_a, 1);
    chk("abort_busy", busy_a, 0);
    chk("abort_no_enable", en_a, 0);
    tick();
    chk("abort_done_cleared", done_a, 0);
    chk("abort_busy_after", busy_a, 0);
    chk("abort_no_pending", exp_a.size(), 0);

    // start together with abort in IDLE: nothing happens
    start_a = 1'b1;
    abort_a = 1'b1;
    tick();
    start_a = 1'b0;
    abort_a = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      seen = seen | busy_a | done_a | en_a;
    end
    chk("start_abort_idle_quiet", seen, 0);

    // Restart after abort begins at s0a0
    ready_a = 1'b1;
    for (int i = 0; i < NENT; i++) exp_a.push_back(exp_entry(i));
    pulse_start(1'b0);
    wait_done(1'b0, n);
    chk("restart_cycles", n, 2 * DEP * 3 + 1 + CK);
    chk("restart_all_popped", exp_a.size(), 0);

    // reset_N asserted during WAIT
    pulse_start(1'b0);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!en_a && n < 20);
    chk("rst_saw_issue", en_a, 1);
    @(negedge clock);
    reset_N = 1'b0;
    #1;
    chk_all_zero_a("rst_mid");
    tick();
    tick();
    reset_N = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      seen = seen | en_a | busy_a;
    end
    chk("rst_no_request_after_release", seen, 0);
    chk("rst_no_pending", exp_a.size(), 0);

    // READ_LATENCY=3 instance: full dump with garbage before the data cycle
    ready_b = 1'b1;
    for (int i = 0; i < NENT; i++) exp_b.push_back(exp_entry(i));
    pulse_start(1'b1);
    wait_done(1'b1, n);
    chk("lat3_dump_cycles", n, 2 * DEP * 5 + 1 + CK);
    chk("lat3_all_popped", exp_b.size(), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
